// File: rtl/cordic_seq_pkg.sv
// rtl/cordic_seq_pkg.sv - shared types and constants for the CORDIC sum sequencer
package cordic_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_ISSUE,
    S_A_WAIT,
    S_B_ISSUE,
    S_B_WAIT,
    S_ADD_ISSUE,
    S_ADD_WAIT,
    S_DONE,
    S_ERR
  } seq_state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam int          WD_W = 16;

endpackage

// File: rtl/cordic_sum_sequencer_watchdog.sv
// rtl/cordic_sum_sequencer_watchdog.sv - per-phase wait counter shared by all WAIT states
module phase_watchdog #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The owning phase leaves its WAIT state on expiry, so the counter never runs past limit.
  assign expired = enable && (count_q == limit);

endmodule

// File: rtl/cordic_sum_sequencer.sv
// rtl/cordic_sum_sequencer.sv - time-shares one CORDIC core and one adder to return f(a)+f(b)
module cordic_sum_sequencer
  import cordic_seq_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        error,
  output logic        busy,
  output logic        cordic_start,
  output logic [31:0] cordic_data,
  input  logic [31:0] cordic_result,
  input  logic        cordic_done,
  output logic        add_enable,
  output logic [31:0] add_dataa,
  output logic [31:0] add_datab,
  input  logic [31:0] add_result,
  input  logic        add_done
);

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_WAIT - 1);

  seq_state_t  state_q, state_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] cordic_data_q, cordic_data_d;
  logic [31:0] add_dataa_q, add_dataa_d;
  logic [31:0] add_datab_q, add_datab_d;
  logic [31:0] result_q, result_d;
  logic        error_q, error_d;

  logic        in_wait;
  logic        wd_expired;

  assign in_wait = (state_q == S_A_WAIT) || (state_q == S_B_WAIT) || (state_q == S_ADD_WAIT);

  phase_watchdog #(
    .W(WD_W)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!in_wait),
    .enable  (in_wait),
    .limit   (WD_LIMIT),
    .expired (wd_expired)
  );

  // op_a is loaded straight into cordic_data, which then holds it for the whole A phase.
  always_comb begin
    state_d       = state_q;
    op_b_d        = op_b_q;
    cordic_data_d = cordic_data_q;
    add_dataa_d   = add_dataa_q;
    add_datab_d   = add_datab_q;
    result_d      = result_q;
    error_d       = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cordic_data_d = dataa;
          op_b_d        = datab;
          error_d       = 1'b0;
          state_d       = S_A_ISSUE;
        end
      end
      S_A_ISSUE: state_d = S_A_WAIT;
      S_A_WAIT: begin
        if (cordic_done) begin
          add_dataa_d   = cordic_result;
          cordic_data_d = op_b_q;
          state_d       = S_B_ISSUE;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_B_ISSUE: state_d = S_B_WAIT;
      S_B_WAIT: begin
        if (cordic_done) begin
          add_datab_d = cordic_result;
          state_d     = S_ADD_ISSUE;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_ADD_ISSUE: state_d = S_ADD_WAIT;
      S_ADD_WAIT: begin
        if (add_done) begin
          result_d = add_result;
          state_d  = S_DONE;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_ERR) && (state_q != S_ERR)) begin
      result_d = QNAN;
      error_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      op_b_q        <= '0;
      cordic_data_q <= '0;
      add_dataa_q   <= '0;
      add_datab_q   <= '0;
      result_q      <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_b_q        <= op_b_d;
      cordic_data_q <= cordic_data_d;
      add_dataa_q   <= add_dataa_d;
      add_datab_q   <= add_datab_d;
      result_q      <= result_d;
      error_q       <= error_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE) || (state_q == S_ERR);
  assign cordic_start = (state_q == S_A_ISSUE) || (state_q == S_B_ISSUE);
  assign add_enable   = (state_q == S_ADD_ISSUE);
  assign cordic_data  = cordic_data_q;
  assign add_dataa    = add_dataa_q;
  assign add_datab    = add_datab_q;
  assign result       = result_q;
  assign error        = error_q;

endmodule

// File: tb/tb_cordic_sum_sequencer.sv
// tb/tb_cordic_sum_sequencer.sv - self-checking bench for cordic_sum_sequencer
module tb_cordic_sum_sequencer;

  localparam logic [31:0] EXP_QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic [31:0] result;
  logic        done, error, busy, cordic_start, add_enable;
  logic [31:0] cordic_data, add_dataa, add_datab;
  logic [31:0] cordic_result, add_result;
  logic        cordic_done, add_done;

  always #5 clk = ~clk;

  cordic_sum_sequencer #(.MAX_WAIT(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .dataa         (dataa),
    .datab         (datab),
    .result        (result),
    .done          (done),
    .error         (error),
    .busy          (busy),
    .cordic_start  (cordic_start),
    .cordic_data   (cordic_data),
    .cordic_result (cordic_result),
    .cordic_done   (cordic_done),
    .add_enable    (add_enable),
    .add_dataa     (add_dataa),
    .add_datab     (add_datab),
    .add_result    (add_result),
    .add_done      (add_done)
  );

  int n_checks = 0;
  int n_fail = 0;

  // single-precision add through double; operands are always normal numbers
  function automatic real s2r(input logic [31:0] x);
    logic [63:0] d;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2s(s2r(a) + s2r(b));
  endfunction

  function automatic logic [31:0] rand_float();
    return {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
  endfunction

  // external unit models: CORDIC f(x)=x with latency na/nb, adder with latency nadd; 0 = never answers
  int          na = 1, nb = 1, nadd = 1;
  bit          stray_en = 1'b0;
  int          cyc, c_due, a_due, lat_now;
  logic        c_par;
  logic [31:0] c_op, a_sum;

  always_comb lat_now = c_par ? nb : na;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc           <= 0;
      c_par         <= 1'b0;
      c_due         <= -1;
      a_due         <= -1;
      c_op          <= '0;
      a_sum         <= '0;
      cordic_done   <= 1'b0;
      cordic_result <= '0;
      add_done      <= 1'b0;
      add_result    <= '0;
    end else begin
      cyc <= cyc + 1;
      if (cordic_start) begin
        c_par <= ~c_par;
        c_op  <= cordic_data;
        c_due <= (lat_now == 0) ? -1 : cyc + lat_now;
      end
      cordic_done   <= cordic_start ? (lat_now == 1) : (c_due == cyc + 1);
      cordic_result <= cordic_start ? cordic_data : c_op;
      if (add_enable) begin
        a_sum <= fadd(add_dataa, add_datab);
        a_due <= (nadd == 0) ? -1 : cyc + nadd;
      end
      add_done   <= (add_enable ? (nadd == 1) : (a_due == cyc + 1)) ||
                    (stray_en && (cordic_start ? ~c_par : c_par));
      add_result <= add_enable ? fadd(add_dataa, add_datab) : a_sum;
    end
  end

  // observations of the most recent job
  int          j_done_cyc, j_ncs, j_nae, j_cd_bad, j_busy_bad;
  logic        j_busy0, j_err;
  logic [31:0] j_res, j_ada, j_adb;

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int inj_cyc);
    int seen_cs;
    seen_cs = 0;
    j_done_cyc = -1; j_ncs = 0; j_nae = 0; j_cd_bad = 0; j_busy_bad = 0;
    j_res = 'x; j_err = 1'bx; j_ada = 'x; j_adb = 'x;
    @(negedge clk);
    j_busy0 = busy;
    start = 1'b1; dataa = a; datab = b;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      start = (n == inj_cyc);
      if (n == inj_cyc) begin dataa = ~a; datab = ~b; end
      if (busy !== 1'b1) j_busy_bad++;
      if (cordic_start === 1'b1) begin j_ncs++; seen_cs = j_ncs; end
      if (seen_cs == 1 && cordic_data !== a) j_cd_bad++;
      if (seen_cs == 2 && cordic_data !== b) j_cd_bad++;
      if (add_enable === 1'b1) begin j_nae++; j_ada = add_dataa; j_adb = add_datab; end
      if (done === 1'b1) begin
        j_done_cyc = n; j_res = result; j_err = error;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({done, error, busy, cordic_start, add_enable} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {done, error, busy, cordic_start, add_enable}); end
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++; if ({cordic_data, add_dataa, add_datab} !== 96'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {cordic_data, add_dataa, add_datab}); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    na = 1; nb = 1; nadd = 1;
    run_job(32'h4040_0000, 32'h4080_0000, 0);
    n_checks++; if (j_busy0 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_cycle0: got %b want 0", j_busy0); end
    n_checks++; if (j_done_cyc !== 7) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 7", j_done_cyc); end
    n_checks++; if (j_res !== 32'h40E0_0000) begin n_fail++; $display("FAIL basic_result: got %h want 40e00000", j_res); end
    n_checks++; if (j_err !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b want 0", j_err); end
  endtask

  task automatic test_latency();
    logic [31:0] a, b;
    na = 3; nb = 3; nadd = 2;
    a = rand_float(); b = rand_float();
    run_job(a, b, 0);
    n_checks++; if (j_done_cyc !== 12) begin n_fail++; $display("FAIL lat_done_cycle: got %0d want 12", j_done_cyc); end
    n_checks++; if (j_ncs !== 2 || j_nae !== 1) begin n_fail++; $display("FAIL lat_pulses: got cs=%0d ae=%0d want 2/1", j_ncs, j_nae); end
    n_checks++; if (j_cd_bad !== 0) begin n_fail++; $display("FAIL lat_cordic_data: got %0d bad cycles want 0", j_cd_bad); end
    n_checks++; if (j_busy_bad !== 0) begin n_fail++; $display("FAIL lat_busy: got %0d low cycles want 0", j_busy_bad); end
    n_checks++; if (j_ada !== a || j_adb !== b) begin n_fail++; $display("FAIL lat_add_operands: got %h/%h want %h/%h", j_ada, j_adb, a, b); end
    n_checks++; if (j_res !== fadd(a, b)) begin n_fail++; $display("FAIL lat_result: got %h want %h", j_res, fadd(a, b)); end
  endtask

  task automatic test_ignore_start();
    logic [31:0] a, b;
    na = 2; nb = 2; nadd = 1;
    a = rand_float(); b = rand_float();
    run_job(a, b, 5);  // cycle 5 is the first B_WAIT cycle
    n_checks++; if (j_done_cyc !== 9) begin n_fail++; $display("FAIL ign_done_cycle: got %0d want 9", j_done_cyc); end
    n_checks++; if (j_res !== fadd(a, b)) begin n_fail++; $display("FAIL ign_result: got %h want %h", j_res, fadd(a, b)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    na = 1; nb = 2; nadd = 3;
    a = rand_float(); b = rand_float();
    run_job(a, b, 0);  // accepted in the cycle right after the previous done
    n_checks++; if (j_busy0 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after_done: got %b want 0", j_busy0); end
    n_checks++; if (j_done_cyc !== 10 || j_res !== fadd(a, b)) begin n_fail++; $display("FAIL b2b_job: got cyc=%0d res=%h want 10/%h", j_done_cyc, j_res, fadd(a, b)); end
  endtask

  task automatic test_done_restart();
    start = 1'b1; dataa = rand_float(); datab = rand_float();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_cycle_start: got busy=%b want 0", busy); end
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_cycle_start_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_timeout();
    logic [31:0] a, b;
    na = 1; nb = 0; nadd = 1;
    a = rand_float(); b = rand_float();
    run_job(a, b, 0);
    n_checks++; if (j_done_cyc !== 12) begin n_fail++; $display("FAIL to_done_cycle: got %0d want 12", j_done_cyc); end
    n_checks++; if (j_err !== 1'b1 || j_res !== EXP_QNAN) begin n_fail++; $display("FAIL to_err_result: got err=%b res=%h want 1/7fc00000", j_err, j_res); end
    n_checks++; if (j_nae !== 0) begin n_fail++; $display("FAIL to_no_add: got %0d want 0", j_nae); end
    nb = 1;
    run_job(b, a, 0);
    n_checks++; if (j_err !== 1'b0 || j_res !== fadd(b, a) || j_done_cyc !== 7) begin n_fail++; $display("FAIL to_recover: got err=%b res=%h cyc=%0d want 0/%h/7", j_err, j_res, j_done_cyc, fadd(b, a)); end
    nb = 8;
    run_job(a, b, 0);
    n_checks++; if (j_err !== 1'b0 || j_res !== fadd(a, b) || j_done_cyc !== 14) begin n_fail++; $display("FAIL to_last_cycle_wins: got err=%b res=%h cyc=%0d want 0/%h/14", j_err, j_res, j_done_cyc, fadd(a, b)); end
    nb = 9;
    run_job(a, b, 0);
    n_checks++; if (j_err !== 1'b1 || j_done_cyc !== 12) begin n_fail++; $display("FAIL to_one_late: got err=%b cyc=%0d want 1/12", j_err, j_done_cyc); end
    na = 1; nb = 1; nadd = 0;
    run_job(a, b, 0);
    n_checks++; if (j_err !== 1'b1 || j_res !== EXP_QNAN || j_done_cyc !== 14) begin n_fail++; $display("FAIL to_add_phase: got err=%b res=%h cyc=%0d want 1/7fc00000/14", j_err, j_res, j_done_cyc); end
  endtask

  task automatic test_stray();
    logic [31:0] a, b;
    na = 3; nb = 2; nadd = 2; stray_en = 1'b1;
    a = rand_float(); b = rand_float();
    run_job(a, b, 0);
    stray_en = 1'b0;
    n_checks++; if (j_done_cyc !== 11 || j_res !== fadd(a, b)) begin n_fail++; $display("FAIL stray_add_done: got cyc=%0d res=%h want 11/%h", j_done_cyc, j_res, fadd(a, b)); end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int k = 0; k < 8; k++) begin
      na = $urandom_range(1, 6); nb = $urandom_range(1, 6); nadd = $urandom_range(1, 6);
      a = rand_float(); b = rand_float();
      run_job(a, b, 0);
      n_checks++; if (j_done_cyc !== 4 + na + nb + nadd || j_err !== 1'b0) begin n_fail++; $display("FAIL rand_timing[%0d]: got cyc=%0d err=%b want %0d/0", k, j_done_cyc, j_err, 4 + na + nb + nadd); end
      n_checks++; if (j_res !== fadd(a, b) || j_ada !== a || j_adb !== b) begin n_fail++; $display("FAIL rand_result[%0d]: got %h (%h/%h) want %h", k, j_res, j_ada, j_adb, fadd(a, b)); end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    na = 1; nb = 1; nadd = 0; seen = 0;
    @(negedge clk);
    start = 1'b1; dataa = rand_float(); datab = rand_float();
    for (int n = 0; n < 20 && seen == 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (add_enable === 1'b1) seen = 1;
    end
    n_checks++; if (seen !== 1) begin n_fail++; $display("FAIL mid_reach_add: got %0d want 1", seen); end
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if ({done, error, busy, cordic_start, add_enable} !== 5'b0 || {result, cordic_data, add_dataa, add_datab} !== 128'd0) begin n_fail++; $display("FAIL mid_async_clear: got flags=%b data=%h want 0", {done, error, busy, cordic_start, add_enable}, {result, cordic_data, add_dataa, add_datab}); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) seen++; end
    reset_n = 1'b1;
    repeat (2) begin @(negedge clk); if (done !== 1'b0) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d done cycles want 0", seen); end
    nadd = 1;
    run_job(32'h4040_0000, 32'h4080_0000, 0);
    n_checks++; if (j_done_cyc !== 7 || j_res !== 32'h40E0_0000 || j_err !== 1'b0) begin n_fail++; $display("FAIL mid_recover: got cyc=%0d res=%h err=%b want 7/40e00000/0", j_done_cyc, j_res, j_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_ignore_start();
    test_back_to_back();
    test_done_restart();
    test_timeout();
    test_stray();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_sum_sequencer.md
# cordic_sum_sequencer

Controller that time-shares one CORDIC core and one floating-point adder to compute result = f(dataa) + f(datab) for a two-operand custom instruction. It replaces two parallel CORDIC instances with one: it issues operand A, then operand B, to the core, latches both results, launches the adder, and returns the sum with a one-cycle `done`. A per-phase watchdog aborts the operation with an error flag and a quiet NaN if any unit fails to answer.

## Interface
- `MAX_WAIT`, 255: cycles allowed in any wait phase before timeout (range 2–65535).
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `dataa`, `datab`  in  32  IEEE-754 single operands; captured when `start` is accepted.
- `result`  out  32  sum, or 0x7FC00000 on error; held until the next accepted `start`.
- `done`  out  1  one-cycle pulse; `result`/`error` valid in that cycle.
- `error`  out  1  set with `done` on timeout; held with `result`.
- `busy`  out  1  high in every state except IDLE.
- `cordic_start`  out  1  one-cycle issue pulse to the CORDIC core.
- `cordic_data`  out  32  operand to the core; stable from issue through the core's `done`.
- `cordic_result`  in  32  core output; valid when `cordic_done` is high.
- `cordic_done`  in  1  core completion.
- `add_enable`  out  1  one-cycle issue pulse to the adder.
- `add_dataa`, `add_datab`  out  32  latched CORDIC results for A and B.
- `add_result`  in  32  adder output; valid when `add_done` is high.
- `add_done`  in  1  adder completion.

## Operation
- States: IDLE, A_ISSUE, A_WAIT, B_ISSUE, B_WAIT, ADD_ISSUE, ADD_WAIT, DONE, ERR.
- IDLE, `start`=1: capture `dataa`/`datab` into op_a/op_b, clear `error`, go to A_ISSUE.
- A_ISSUE: `cordic_start`=1, `cordic_data`=op_a, go to A_WAIT.
- A_WAIT: on `cordic_done`, latch `cordic_result` into `add_dataa` and go to B_ISSUE.
- B_ISSUE and B_WAIT: same as the A phase using op_b; the result is latched into `add_datab`, then go to ADD_ISSUE.
- ADD_ISSUE: `add_enable`=1, go to ADD_WAIT.
- ADD_WAIT: on `add_done`, latch `add_result` into `result` and go to DONE.
- DONE: `done`=1, go to IDLE.
- ERR: `result`=0x7FC00000, `error`=1, `done`=1, go to IDLE.
- `cordic_data` shows op_a in A states, op_b in B states, and holds its last value elsewhere.
- `cordic_start` and `add_enable` are decoded from the registered state. They are 1 only in their ISSUE state.
- Watchdog:
  - A 16-bit counter clears on entry to each WAIT state and increments every cycle spent there.
  - If the counter reaches `MAX_WAIT`−1 and the completion signal is still low, go to ERR.
  - A completion signal arriving in that same cycle wins over the timeout.
- `cordic_done` and `add_done` are ignored outside their own WAIT state, including a stray `add_done` during the CORDIC phases.
- `start` is ignored while `busy`; requests are not queued.
- A `start` sampled in the DONE or ERR cycle is ignored. The earliest accepted restart is the cycle after `done`.

## Timing
- Reset (asynchronous, any state): state=IDLE. `result`=0, `done`=0, `error`=0, `busy`=0, `cordic_start`=0, `add_enable`=0. `cordic_data`, `add_dataa` and `add_datab` are 0. Watchdog counter is 0.
- Reset mid-operation abandons the job with no `done`. The core and adder must share `reset_n` so that no stale completion survives.
- Latency definitions:
  - Start accepted in cycle 0.
  - Na, Nb = cycles from `cordic_start` to `cordic_done`, each ≥ 1.
  - Nadd = cycles from `add_enable` to `add_done`, ≥ 1.
  - `done` is high in cycle 4+Na+Nb+Nadd. With every unit answering in one cycle, `done` is high in cycle 7.
- Throughput: one job per 5+Na+Nb+Nadd cycles.

## Structure
- Package `cordic_seq_pkg` holds:
  - the state enum `seq_state_t`;
  - `QNAN` = 32'h7FC00000;
  - `WD_W` = 16, the watchdog width.
- Optional sub-module `phase_watchdog` (clear, enable, limit → expired), instantiated once and shared by the three WAIT states. Everything else stays in the top FSM.

## Test plan
- Reset, then `start` with Na=Nb=Nadd=1 and a model CORDIC f(x)=x, dataa=3.0, datab=4.0 → `done` in cycle 7, `result`=0x40E00000, `error`=0.
- Na=3, Nb=3, Nadd=2 → exactly one `cordic_start` pulse per phase; `cordic_data` stable at dataa then datab; `done` in cycle 12; `busy` high in cycles 1–12.
- `start` pulsed during B_WAIT with different operands → ignored; the first result is unchanged; a `start` in the cycle after `done` is accepted.
- With `MAX_WAIT`=8, the core never asserts `cordic_done` in B_WAIT → ERR after 8 wait cycles; `done`=1, `error`=1, `result`=0x7FC00000; the next job clears `error`.
- With `MAX_WAIT`=8, `cordic_done` arrives in the 8th wait cycle → the response is accepted, no error.
- `reset_n` low during ADD_WAIT → all outputs 0 at once and no `done`; a subsequent job completes normally.
